// File: rtl/ir_assembler.sv
// Instruction-register assembler: packs BYTES bus words into one instruction.
// Optional sticky overrun flag under IR_ASSEMBLER_OVERRUN_EN.
module ir_assembler #(
  parameter int DATA_W     = 8,
  parameter int BYTES      = 2,
  parameter int BIG_ENDIAN = 1,
  localparam int OUT_W     = DATA_W * BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  input  logic              ir_ready,
  output logic [OUT_W-1:0]  opc_iraddr,
  output logic              ir_valid,
  output logic              ena_rdy,
`ifdef IR_ASSEMBLER_OVERRUN_EN
  output logic              overrun,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [OUT_W-1:0] sh;
  logic [OUT_W-1:0] merged;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             complete;

  // Final word stalls only while the output stage is still occupied.
  assign ena_rdy  = !flush && !(cnt == LAST && ir_valid && !ir_ready);
  assign accept   = ena && ena_rdy;
  assign complete = accept && (cnt == LAST);
  assign busy     = (cnt != '0);

  // Shadow word with the incoming bus word dropped into slot cnt.
  always_comb begin
    merged = sh;
    for (int k = 0; k < BYTES; k++) begin
      if (cnt == CNT_W'(k)) begin
        if (BIG_ENDIAN != 0)
          merged[OUT_W-(k+1)*DATA_W +: DATA_W] = data;
        else
          merged[k*DATA_W +: DATA_W] = data;
      end
    end
  end

  // Collect words, hand completed instructions to the output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh         <= '0;
      cnt        <= '0;
      opc_iraddr <= '0;
      ir_valid   <= 1'b0;
    end else begin
      if (flush) begin
        sh  <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (cnt == LAST) begin
          opc_iraddr <= merged;
          sh         <= '0;
          cnt        <= '0;
        end else begin
          sh  <= merged;
          cnt <= cnt + 1'b1;
        end
      end
      if (complete)
        ir_valid <= 1'b1;
      else if (ir_valid && ir_ready)
        ir_valid <= 1'b0;
    end
  end

`ifdef IR_ASSEMBLER_OVERRUN_EN
  // Sticky record of a strobe dropped by back-pressure.
  always_ff @(posedge clk) begin
    if (!rst)
      overrun <= 1'b0;
    else if (ena && !ena_rdy && !flush)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: default big-endian 2-word instance
// plus a little-endian 4-word instance.
module tb_ir_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ir_ready;
  logic        ena_a, ena_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] opc_a;
  logic [31:0] opc_b;
  logic        valid_a, valid_b;
  logic        rdy_a, rdy_b;
  logic        busy_a, busy_b;
`ifdef IR_ASSEMBLER_OVERRUN_EN
  logic        ovr_a, ovr_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ir_assembler u_a (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena_a),
    .data       (data_a),
    .flush      (flush),
    .ir_ready   (ir_ready),
    .opc_iraddr (opc_a),
    .ir_valid   (valid_a),
    .ena_rdy    (rdy_a),
`ifdef IR_ASSEMBLER_OVERRUN_EN
    .overrun    (ovr_a),
`endif
    .busy       (busy_a)
  );

  ir_assembler #(.DATA_W(8), .BYTES(4), .BIG_ENDIAN(0)) u_b (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena_b),
    .data       (data_b),
    .flush      (flush),
    .ir_ready   (ir_ready),
    .opc_iraddr (opc_b),
    .ir_valid   (valid_b),
    .ena_rdy    (rdy_b),
`ifdef IR_ASSEMBLER_OVERRUN_EN
    .overrun    (ovr_b),
`endif
    .busy       (busy_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    ena_a  = 1'b1;
    data_a = d;
    tick();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; ir_ready = 1'b1;
    ena_a = 1'b0; data_a = '0; ena_b = 1'b0; data_b = '0;
    tick(); tick();
    check("rst_opc", 32'(opc_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_opc_b", opc_b, 32'h0);
`ifdef IR_ASSEMBLER_OVERRUN_EN
    check("rst_ovr", 32'(ovr_a), 32'h0);
`endif
    rst = 1'b1;
    #1;
    check("rst_rdy", 32'(rdy_a), 32'h1);

    send_a(8'hA5);
    check("t1_busy", 32'(busy_a), 32'h1);
    check("t1_valid0", 32'(valid_a), 32'h0);
    send_a(8'h3C);
    check("t1_opc", 32'(opc_a), 32'hA53C);
    check("t1_valid1", 32'(valid_a), 32'h1);
    check("t1_busy0", 32'(busy_a), 32'h0);
    ena_a = 1'b0;
    tick();
    check("t1_pulse", 32'(valid_a), 32'h0);

    ir_ready = 1'b0;
    send_a(8'hA5);
    send_a(8'h3C);
    check("bp_opc", 32'(opc_a), 32'hA53C);
    data_a = 8'h01;
    #1;
    check("bp_rdy01", 32'(rdy_a), 32'h1);
    tick();
    check("bp_hold1", 32'(opc_a), 32'hA53C);
    check("bp_busy", 32'(busy_a), 32'h1);
    data_a = 8'h02;
    #1;
    check("bp_rdy02", 32'(rdy_a), 32'h0);
    tick();
    check("bp_hold2", 32'(opc_a), 32'hA53C);
    check("bp_valid", 32'(valid_a), 32'h1);
    check("bp_busy2", 32'(busy_a), 32'h1);
`ifdef IR_ASSEMBLER_OVERRUN_EN
    check("bp_ovr", 32'(ovr_a), 32'h1);
`endif
    ir_ready = 1'b1;
    #1;
    check("bp_rdy_up", 32'(rdy_a), 32'h1);
    tick();
    check("bp_opc2", 32'(opc_a), 32'h0102);
    check("bp_valid2", 32'(valid_a), 32'h1);
    ena_a = 1'b0;
    tick();
    check("bp_drain", 32'(valid_a), 32'h0);

    send_a(8'h77);
    check("fl_busy1", 32'(busy_a), 32'h1);
    ena_a = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy0", 32'(busy_a), 32'h0);
`ifdef IR_ASSEMBLER_OVERRUN_EN
    check("fl_ovr", 32'(ovr_a), 32'h1);
`endif
    send_a(8'h55);
    send_a(8'h66);
    check("fl_opc", 32'(opc_a), 32'h5566);
    check("fl_valid", 32'(valid_a), 32'h1);
    ena_a = 1'b0;
    tick();

    send_a(8'h99);
    ena_a = 1'b0; rst = 1'b0;
    tick();
    check("mr_opc", 32'(opc_a), 32'h0);
    check("mr_valid", 32'(valid_a), 32'h0);
    check("mr_busy", 32'(busy_a), 32'h0);
`ifdef IR_ASSEMBLER_OVERRUN_EN
    check("mr_ovr", 32'(ovr_a), 32'h0);
`endif
    rst = 1'b1;
    send_a(8'h12);
    send_a(8'h34);
    check("mr_opc2", 32'(opc_a), 32'h1234);

    for (int i = 1; i <= 6; i++) begin
      ena_a = 1'b1;
      data_a = 8'(i);
      #1;
      check($sformatf("st_rdy%0d", i), 32'(rdy_a), 32'h1);
      tick();
      if (i % 2 == 0) begin
        check($sformatf("st_opc%0d", i), 32'(opc_a),
              32'(((i - 1) << 8) | i));
        check($sformatf("st_val%0d", i), 32'(valid_a), 32'h1);
      end else begin
        check($sformatf("st_val%0d", i), 32'(valid_a), 32'h0);
      end
    end
    ena_a = 1'b0;
    tick();

    for (int i = 1; i <= 4; i++) begin
      ena_b = 1'b1;
      data_b = 8'(i * 8'h11);
      tick();
      if (i < 4)
        check($sformatf("le_busy%0d", i), 32'(busy_b), 32'h1);
    end
    check("le_opc", opc_b, 32'h44332211);
    check("le_valid", 32'(valid_b), 32'h1);
    ena_b = 1'b0;
    tick();
    check("le_drain", 32'(valid_b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
